// File: rtl/dsi_sync_event_gen_if.sv
// Event queue handshake between dsi_sync_event_gen (master) and the DSI packet formatter (slave).
interface dsi_sync_event_gen_if;
   logic        evt_valid;
   logic        evt_ready;
   logic [5:0]  evt_code;
   logic [15:0] evt_wc;

   modport master (output evt_valid, output evt_code, output evt_wc, input evt_ready);
   modport slave  (input evt_valid, input evt_code, input evt_wc, output evt_ready);
endinterface

// File: rtl/dsi_sync_event_gen.sv
// Converts parallel-video sync/DE edges into a queue of DSI packet events and delays pixels to match.
// Optional macro WC_CHECK_EN adds a per-line byte count check against WC (wc_err).
module dsi_sync_event_gen #(
   parameter logic [15:0] WC         = 16'h05A0,
   parameter bit          VS_POL     = 1'b1,
   parameter bit          HS_POL     = 1'b1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 PIXCLK,
   input  logic                 reset_n,
   input  logic                 VSYNC,
   input  logic                 HSYNC,
   input  logic                 DE,
   input  logic [23:0]          PIXDATA,
   dsi_sync_event_gen_if.master evt,
   output logic                 pix_valid,
   output logic [23:0]          pix_data,
   output logic [11:0]          line_cnt,
   output logic                 overflow,
   output logic                 wc_err
);
   localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW  = AW + 1;
   localparam int unsigned NEV = 5;

   localparam logic [5:0] C_VSS = 6'h01;
   localparam logic [5:0] C_VSE = 6'h11;
   localparam logic [5:0] C_HSS = 6'h21;
   localparam logic [5:0] C_HSE = 6'h31;
   localparam logic [5:0] C_LPS = 6'h3E;

   logic           r_s1_vs, r_s1_hs, r_s1_de;
   logic           r_s2_vs, r_s2_hs, r_s2_de;
   logic [23:0]    r_s1_pix, r_s2_pix;
   logic [1:0]     r_prime;
   logic [NEV-1:0] r_pend;
   logic [5:0]     r_mem [FIFO_DEPTH];
   logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]  r_count;
   logic [11:0]    r_line_cnt;
   logic           r_overflow;

   logic           w_armed;
   logic [NEV-1:0] w_edge;
   logic           w_de_fall;
   logic           w_pop, w_room, w_push;
   logic [NEV-1:0] w_sel;
   logic [5:0]     w_code;
   logic [11:0]    w_lc_base, w_lc_next;

   // Two-stage input pipe, syncs normalised to active-high
   always_ff @(posedge PIXCLK or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_vs  <= 1'b0;
         r_s1_hs  <= 1'b0;
         r_s1_de  <= 1'b0;
         r_s1_pix <= '0;
         r_s2_vs  <= 1'b0;
         r_s2_hs  <= 1'b0;
         r_s2_de  <= 1'b0;
         r_s2_pix <= '0;
         r_prime  <= 2'd0;
      end else begin
         r_s1_vs  <= (VSYNC == VS_POL);
         r_s1_hs  <= (HSYNC == HS_POL);
         r_s1_de  <= DE;
         r_s1_pix <= PIXDATA;
         r_s2_vs  <= r_s1_vs;
         r_s2_hs  <= r_s1_hs;
         r_s2_de  <= r_s1_de;
         r_s2_pix <= r_s1_pix;
         if (r_prime != 2'd2) r_prime <= r_prime + 2'd1;
      end
   end

   // Edges are ignored until s1/s2 both hold post-reset samples
   assign w_armed   = (r_prime == 2'd2);
   assign w_edge    = {w_armed &  r_s1_de & ~r_s2_de,
                       w_armed & ~r_s1_vs & ~r_s1_hs &  r_s2_hs,
                       w_armed & ~r_s1_vs &  r_s1_hs & ~r_s2_hs,
                       w_armed & ~r_s1_vs &  r_s2_vs,
                       w_armed &  r_s1_vs & ~r_s2_vs};
   assign w_de_fall = w_armed & ~r_s1_de & r_s2_de;

   assign w_pop  = (r_count != '0) & evt.evt_ready;
   assign w_room = (r_count != CW'(FIFO_DEPTH)) | w_pop;

   // Retire the highest-priority pending event when the queue can take it
   always_comb begin
      w_sel  = '0;
      w_code = C_VSS;
      if (w_room) begin
         if      (r_pend[0]) begin w_sel = 5'b00001; w_code = C_VSS; end
         else if (r_pend[1]) begin w_sel = 5'b00010; w_code = C_VSE; end
         else if (r_pend[2]) begin w_sel = 5'b00100; w_code = C_HSS; end
         else if (r_pend[3]) begin w_sel = 5'b01000; w_code = C_HSE; end
         else if (r_pend[4]) begin w_sel = 5'b10000; w_code = C_LPS; end
      end
   end
   assign w_push = |w_sel;

   assign w_lc_base = w_sel[0] ? 12'd0 : r_line_cnt;
   assign w_lc_next = (w_de_fall && (w_lc_base != 12'hFFF)) ? w_lc_base + 12'd1 : w_lc_base;

   always_ff @(posedge PIXCLK or negedge reset_n) begin
      if (!reset_n) begin
         r_pend     <= '0;
         r_overflow <= 1'b0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_line_cnt <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         r_pend     <= (r_pend & ~w_sel) | w_edge;
         r_overflow <= r_overflow | (|(w_edge & r_pend & ~w_sel));
         r_line_cnt <= w_lc_next;
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_code;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign evt.evt_valid = (r_count != '0);
   assign evt.evt_code  = r_mem[r_rd_ptr];
   assign evt.evt_wc    = (r_mem[r_rd_ptr] == C_LPS) ? WC : 16'h0000;
   assign pix_valid     = r_s2_de;
   assign pix_data      = r_s2_pix;
   assign line_cnt      = r_line_cnt;
   assign overflow      = r_overflow;

`ifdef WC_CHECK_EN
   logic [15:0] r_pixcnt;
   logic        r_wc_err;
   logic [17:0] w_bytes;

   assign w_bytes = 18'(r_pixcnt) * 18'd3;

   // Active-pixel count per line, checked against WC at DE fall
   always_ff @(posedge PIXCLK or negedge reset_n) begin
      if (!reset_n) begin
         r_pixcnt <= '0;
         r_wc_err <= 1'b0;
      end else begin
         if (w_edge[4])                             r_pixcnt <= 16'd1;
         else if (r_s1_de && (r_pixcnt != 16'hFFFF)) r_pixcnt <= r_pixcnt + 16'd1;
         r_wc_err <= w_de_fall && (w_bytes != 18'(WC));
      end
   end
   assign wc_err = r_wc_err;
`else
   assign wc_err = 1'b0;
`endif
endmodule

// File: tb/tb_dsi_sync_event_gen.sv
// Directed bench for dsi_sync_event_gen: vector table plus hand-written multi-cycle sequences.
module tb_dsi_sync_event_gen;
   localparam logic [15:0] WC = 16'h05A0;
`ifdef WC_CHECK_EN
   localparam bit WC_ON = 1'b1;
`else
   localparam bit WC_ON = 1'b0;
`endif

   logic        PIXCLK = 1'b0;
   logic        reset_n, VSYNC, HSYNC, DE;
   logic [23:0] PIXDATA;
   logic        pix_valid, overflow, wc_err;
   logic [23:0] pix_data;
   logic [11:0] line_cnt;

   dsi_sync_event_gen_if evt_if ();

   dsi_sync_event_gen dut (
      .PIXCLK   (PIXCLK),
      .reset_n  (reset_n),
      .VSYNC    (VSYNC),
      .HSYNC    (HSYNC),
      .DE       (DE),
      .PIXDATA  (PIXDATA),
      .evt      (evt_if),
      .pix_valid(pix_valid),
      .pix_data (pix_data),
      .line_cnt (line_cnt),
      .overflow (overflow),
      .wc_err   (wc_err)
   );

   always #5 PIXCLK = ~PIXCLK;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int wc_hi  = 0;

   typedef struct {
      logic [5:0]  code;
      logic [15:0] wc;
      int          cyc;
   } ev_t;
   ev_t log_q[$];

   always @(posedge PIXCLK) cyc <= cyc + 1;

   // Log every handshake that will complete at the next rising edge
   always @(negedge PIXCLK) begin
      if (reset_n && evt_if.evt_valid && evt_if.evt_ready)
         log_q.push_back('{evt_if.evt_code, evt_if.evt_wc, cyc});
      if (wc_err) wc_hi++;
   end

   typedef struct {
      logic        vs, hs, de;
      logic [23:0] pix;
      logic        v;
      logic [5:0]  code;
      logic        pv;
      logic [23:0] pd;
      logic [11:0] lc;
   } vec_t;
   vec_t tbl[13];

   function automatic vec_t mk(input logic vs, input logic hs, input logic de, input logic [23:0] pix,
                               input logic v, input logic [5:0] code, input logic pv,
                               input logic [23:0] pd, input logic [11:0] lc);
      vec_t r;
      r.vs = vs; r.hs = hs; r.de = de; r.pix = pix;
      r.v = v; r.code = code; r.pv = pv; r.pd = pd; r.lc = lc;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge PIXCLK);
         #1;
      end
   endtask

   task automatic chk_ev(input string nm, input int idx, input logic [5:0] code);
      if (idx < log_q.size()) begin
         chk({nm, "_code"}, 32'(log_q[idx].code), 32'(code));
         chk({nm, "_wc"}, 32'(log_q[idx].wc), (code == 6'h3E) ? 32'(WC) : 32'd0);
      end else begin
         chk({nm, "_missing"}, 32'(log_q.size()), 32'(idx + 1));
      end
   endtask

   task automatic line(input int npix);
      HSYNC = 1'b1; step(3);
      HSYNC = 1'b0; step(3);
      DE = 1'b1;
      for (int i = 0; i < npix; i++) begin
         PIXDATA = 24'(i + 1);
         step(1);
      end
      DE = 1'b0;
      PIXDATA = '0;
   endtask

   initial begin
      int mark;
      int hi0;

      tbl[0]  = mk(1, 0, 0, 24'h0,      0, 6'h00, 0, 24'h0,      12'd1);
      tbl[1]  = mk(1, 0, 0, 24'h0,      0, 6'h00, 0, 24'h0,      12'd1);
      tbl[2]  = mk(0, 0, 0, 24'h0,      1, 6'h01, 0, 24'h0,      12'd0);
      tbl[3]  = mk(0, 0, 0, 24'h0,      0, 6'h00, 0, 24'h0,      12'd0);
      tbl[4]  = mk(0, 1, 0, 24'h0,      1, 6'h11, 0, 24'h0,      12'd0);
      tbl[5]  = mk(0, 1, 0, 24'h0,      0, 6'h00, 0, 24'h0,      12'd0);
      tbl[6]  = mk(0, 0, 0, 24'h0,      1, 6'h21, 0, 24'h0,      12'd0);
      tbl[7]  = mk(0, 0, 1, 24'h112233, 0, 6'h00, 0, 24'h0,      12'd0);
      tbl[8]  = mk(0, 0, 1, 24'h445566, 1, 6'h31, 1, 24'h112233, 12'd0);
      tbl[9]  = mk(0, 0, 1, 24'h778899, 1, 6'h3E, 1, 24'h445566, 12'd0);
      tbl[10] = mk(0, 0, 0, 24'h0,      0, 6'h00, 1, 24'h778899, 12'd0);
      tbl[11] = mk(0, 0, 0, 24'h0,      0, 6'h00, 0, 24'h0,      12'd1);
      tbl[12] = mk(0, 0, 0, 24'h0,      0, 6'h00, 0, 24'h0,      12'd1);

      // T1: reset with VSYNC already active
      reset_n = 1'b0; VSYNC = 1'b1; HSYNC = 1'b0; DE = 1'b0; PIXDATA = '0;
      evt_if.evt_ready = 1'b1;
      step(3);
      chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
      chk("rst_code", 32'(evt_if.evt_code), 32'd0);
      chk("rst_wc", 32'(evt_if.evt_wc), 32'd0);
      chk("rst_pv", 32'(pix_valid), 32'd0);
      chk("rst_pd", 32'(pix_data), 32'd0);
      chk("rst_lc", 32'(line_cnt), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_wcerr", 32'(wc_err), 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("t1_no_vss", 32'(evt_if.evt_valid), 32'd0);
      end
      chk("t1_log_empty", 32'(log_q.size()), 32'd0);
      chk("t1_ovf", 32'(overflow), 32'd0);
      VSYNC = 1'b0;
      step(6);
      chk_ev("t1_vse", 0, 6'h11);
      chk("t1_log_n", 32'(log_q.size()), 32'd1);

      // T2: full 480-pixel line outside VSYNC
      mark = log_q.size();
      hi0  = wc_hi;
      line(480);
      step(10);
      chk_ev("t2_hss", mark, 6'h21);
      chk_ev("t2_hse", mark + 1, 6'h31);
      chk_ev("t2_lps", mark + 2, 6'h3E);
      chk("t2_log_n", 32'(log_q.size()), 32'(mark + 3));
      chk("t2_lc", 32'(line_cnt), 32'd1);
      chk("t2_wcerr_pulses", 32'(wc_hi - hi0), 32'd0);
      chk("t2_ovf", 32'(overflow), 32'd0);

      // Cycle-by-cycle vector table: VS pulse, HS pulse, 3-pixel line
      for (int i = 0; i < 13; i++) begin
         VSYNC = tbl[i].vs; HSYNC = tbl[i].hs; DE = tbl[i].de; PIXDATA = tbl[i].pix;
         step(1);
         chk($sformatf("vec%0d_valid", i), 32'(evt_if.evt_valid), 32'(tbl[i].v));
         if (tbl[i].v) begin
            chk($sformatf("vec%0d_code", i), 32'(evt_if.evt_code), 32'(tbl[i].code));
            chk($sformatf("vec%0d_wc", i), 32'(evt_if.evt_wc),
                (tbl[i].code == 6'h3E) ? 32'(WC) : 32'd0);
         end
         chk($sformatf("vec%0d_pv", i), 32'(pix_valid), 32'(tbl[i].pv));
         if (tbl[i].pv) chk($sformatf("vec%0d_pd", i), 32'(pix_data), 32'(tbl[i].pd));
         chk($sformatf("vec%0d_lc", i), 32'(line_cnt), 32'(tbl[i].lc));
      end

      // T3: coincident VS/HS rise, then VS fall with HS rise
      mark = log_q.size();
      VSYNC = 1'b1; HSYNC = 1'b1; step(6);
      HSYNC = 1'b0; step(6);
      VSYNC = 1'b0; HSYNC = 1'b1; step(6);
      HSYNC = 1'b0; step(8);
      chk_ev("t3_vss", mark, 6'h01);
      chk_ev("t3_vse", mark + 1, 6'h11);
      chk_ev("t3_hss", mark + 2, 6'h21);
      chk_ev("t3_hse", mark + 3, 6'h31);
      chk("t3_log_n", 32'(log_q.size()), 32'(mark + 4));
      if (log_q.size() >= mark + 3)
         chk("t3_consecutive", 32'(log_q[mark + 2].cyc - log_q[mark + 1].cyc), 32'd1);
      chk("t3_lc", 32'(line_cnt), 32'd0);

      // T4: stalled consumer, queue fills, repeat edge overflows
      evt_if.evt_ready = 1'b0;
      mark = log_q.size();
      VSYNC = 1'b1; step(3);
      VSYNC = 1'b0; step(3);
      HSYNC = 1'b1; step(3);
      HSYNC = 1'b0; step(3);
      DE = 1'b1; step(3);
      DE = 1'b0; step(6);
      for (int i = 0; i < 3; i++) begin
         chk("t4_valid", 32'(evt_if.evt_valid), 32'd1);
         chk("t4_head", 32'(evt_if.evt_code), 32'h01);
         chk("t4_head_wc", 32'(evt_if.evt_wc), 32'd0);
         step(1);
      end
      chk("t4_ovf_before", 32'(overflow), 32'd0);
      DE = 1'b1; step(3);
      DE = 1'b0; step(3);
      chk("t4_ovf_set", 32'(overflow), 32'd1);
      evt_if.evt_ready = 1'b1;
      step(12);
      chk_ev("t4_q0", mark, 6'h01);
      chk_ev("t4_q1", mark + 1, 6'h11);
      chk_ev("t4_q2", mark + 2, 6'h21);
      chk_ev("t4_q3", mark + 3, 6'h31);
      chk_ev("t4_q4", mark + 4, 6'h3E);
      chk("t4_log_n", 32'(log_q.size()), 32'(mark + 5));
      chk("t4_drained", 32'(evt_if.evt_valid), 32'd0);
      chk("t4_ovf_sticky", 32'(overflow), 32'd1);
      chk("t4_lc", 32'(line_cnt), 32'd2);

      // T5: short line (479 px) then exact line (480 px)
      hi0 = wc_hi;
      line(479);
      step(1);
      chk("t5_short_pre", 32'(wc_err), 32'd0);
      step(1);
      chk("t5_short_pulse", 32'(wc_err), 32'(WC_ON));
      chk("t5_short_lc", 32'(line_cnt), 32'd3);
      step(1);
      chk("t5_short_post", 32'(wc_err), 32'd0);
      step(4);
      chk("t5_short_npulse", 32'(wc_hi - hi0), 32'(WC_ON));
      hi0 = wc_hi;
      line(480);
      step(2);
      chk("t5_exact_nopulse", 32'(wc_err), 32'd0);
      chk("t5_exact_lc", 32'(line_cnt), 32'd4);
      step(4);
      chk("t5_exact_npulse", 32'(wc_hi - hi0), 32'd0);

      // T6: one-cycle reset in the middle of a line
      evt_if.evt_ready = 1'b0;
      HSYNC = 1'b1; step(3);
      HSYNC = 1'b0; step(3);
      DE = 1'b1; PIXDATA = 24'hABCDEF; step(4);
      chk("t6_pre_valid", 32'(evt_if.evt_valid), 32'd1);
      chk("t6_pre_pv", 32'(pix_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(evt_if.evt_valid), 32'd0);
      chk("t6_rst_lc", 32'(line_cnt), 32'd0);
      chk("t6_rst_pv", 32'(pix_valid), 32'd0);
      chk("t6_rst_pd", 32'(pix_data), 32'd0);
      chk("t6_rst_ovf", 32'(overflow), 32'd0);
      step(1);
      reset_n = 1'b1;
      evt_if.evt_ready = 1'b1;
      mark = log_q.size();
      step(5);
      DE = 1'b0; PIXDATA = '0;
      step(5);
      chk("t6_no_partial", 32'(log_q.size()), 32'(mark));
      line(6);
      step(10);
      chk_ev("t6_hss", mark, 6'h21);
      chk_ev("t6_hse", mark + 1, 6'h31);
      chk_ev("t6_lps", mark + 2, 6'h3E);
      chk("t6_log_n", 32'(log_q.size()), 32'(mark + 3));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end
endmodule
